// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates interrupts, exceptions and MRET,
// owns the M-mode trap CSRs and issues a one-cycle flush/redirect.
module trap_controller #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        exception_taken,
    input  logic [31:0] exception_cause,
    input  logic [31:0] exception_val,
    input  logic        mret,
    input  logic        irq_external,
    input  logic        irq_software,
    input  logic        irq_timer,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        trap_req,
    output logic [31:0] trap_pc,
    output logic        busy,
    output logic        irq_en
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [31:0] IRQ_MASK   = 32'h0000_0888;

    state_e      state_q, state_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        trap_req_q, trap_req_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        busy_q, busy_d;

    logic [31:0] mip_s;
    logic [31:0] irq_pend_s;
    logic [3:0]  irq_code_s;
    logic        accept_s;
    logic        take_irq_s;
    logic        take_exc_s;
    logic        take_mret_s;
    logic [31:0] vec_base_s;
    logic        unused_pc_s;

    assign mip_s       = {20'h0_0000, irq_external, 3'b000, irq_timer, 3'b000, irq_software, 3'b000};
    assign irq_pend_s  = mie_q & mip_s;
    assign accept_s    = (state_q == ST_IDLE) && instr_valid;
    assign take_irq_s  = accept_s && mstatus_mie_q && (|irq_pend_s);
    assign take_exc_s  = accept_s && !take_irq_s && exception_taken;
    assign take_mret_s = accept_s && !take_irq_s && !exception_taken && mret;
    assign vec_base_s  = {mtvec_q[31:2], 2'b00};
    // The low PC bits never reach mepc, which is always word-aligned.
    assign unused_pc_s = ^pc[1:0];

    // Fixed interrupt priority: external, then software, then timer.
    always_comb begin
        irq_code_s = 4'd7;
        if (irq_pend_s[11]) begin
            irq_code_s = 4'd11;
        end else if (irq_pend_s[3]) begin
            irq_code_s = 4'd3;
        end else begin
            irq_code_s = 4'd7;
        end
    end

    // Next-state: trap/MRET commit, CSR writes, redirect sequencing.
    always_comb begin
        state_d        = state_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        trap_req_d     = 1'b0;
        trap_pc_d      = trap_pc_q;
        busy_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take_irq_s || take_exc_s) begin
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                    mepc_d         = {pc[31:2], 2'b00};
                    state_d        = ST_REDIRECT;
                    trap_req_d     = 1'b1;
                    busy_d         = 1'b1;
                    if (take_irq_s) begin
                        mcause_d = {1'b1, 27'h000_0000, irq_code_s};
                        mtval_d  = 32'h0000_0000;
                        if (VECTORED_EN && mtvec_q[0]) begin
                            trap_pc_d = vec_base_s + {26'h000_0000, irq_code_s, 2'b00};
                        end else begin
                            trap_pc_d = vec_base_s;
                        end
                    end else begin
                        mcause_d  = exception_cause;
                        mtval_d   = exception_val;
                        trap_pc_d = vec_base_s;
                    end
                end else if (take_mret_s) begin
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                    trap_pc_d      = mepc_q;
                    state_d        = ST_REDIRECT;
                    trap_req_d     = 1'b1;
                    busy_d         = 1'b1;
                end else if (csr_we) begin
                    case (csr_addr)
                        A_MSTATUS: begin
                            mstatus_mie_d  = csr_wdata[3];
                            mstatus_mpie_d = csr_wdata[7];
                        end
                        A_MIE:      mie_d      = csr_wdata & IRQ_MASK;
                        A_MTVEC:    mtvec_d    = VECTORED_EN ? {csr_wdata[31:2], 1'b0, csr_wdata[0]}
                                                             : {csr_wdata[31:2], 2'b00};
                        A_MSCRATCH: mscratch_d = csr_wdata;
                        A_MEPC:     mepc_d     = {csr_wdata[31:2], 2'b00};
                        A_MCAUSE:   mcause_d   = csr_wdata;
                        A_MTVAL:    mtval_d    = csr_wdata;
                        default:    mscratch_d = mscratch_q;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State, CSR and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0000_0000;
            mtvec_q        <= RESET_MTVEC;
            mscratch_q     <= 32'h0000_0000;
            mepc_q         <= 32'h0000_0000;
            mcause_q       <= 32'h0000_0000;
            mtval_q        <= 32'h0000_0000;
            trap_req_q     <= 1'b0;
            trap_pc_q      <= 32'h0000_0000;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            trap_req_q     <= trap_req_d;
            trap_pc_q      <= trap_pc_d;
            busy_q         <= busy_d;
        end
    end

    // CSR read mux; unowned addresses read as zero.
    always_comb begin
        csr_rdata = 32'h0000_0000;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = {19'h0_0000, 2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            A_MIE:      csr_rdata = mie_q;
            A_MTVEC:    csr_rdata = mtvec_q;
            A_MSCRATCH: csr_rdata = mscratch_q;
            A_MEPC:     csr_rdata = mepc_q;
            A_MCAUSE:   csr_rdata = mcause_q;
            A_MTVAL:    csr_rdata = mtval_q;
            A_MIP:      csr_rdata = mip_s;
            default:    csr_rdata = 32'h0000_0000;
        endcase
    end

    assign trap_req = trap_req_q;
    assign trap_pc  = trap_pc_q;
    assign busy     = busy_q;
    assign irq_en   = mstatus_mie_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed vector table, reset
// during redirect, and random stimulus against a behavioural CSR model.
module tb_trap_controller;

    localparam logic [31:0] RST_TVEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, exception_taken, mret;
    logic [31:0] pc, exception_cause, exception_val;
    logic        irq_external, irq_software, irq_timer;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata, trap_pc;
    logic        trap_req, busy, irq_en;

    trap_controller #(.RESET_MTVEC(RST_TVEC), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc),
        .exception_taken(exception_taken), .exception_cause(exception_cause),
        .exception_val(exception_val), .mret(mret), .irq_external(irq_external),
        .irq_software(irq_software), .irq_timer(irq_timer), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .trap_req(trap_req), .trap_pc(trap_pc), .busy(busy), .irq_en(irq_en)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // irq field order: {external, software, timer}
    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        exc;
        logic [31:0] cause;
        logic [31:0] val;
        logic        mret;
        logic [2:0]  irq;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_busy;
        logic        e_en;
    } vec_t;

    vec_t vecs[24];
    logic [11:0] addr_list[9];

    // behavioural model of the architectural state
    logic        m_mie, m_mpie, m_redirect, m_treq, m_busy;
    logic [31:0] m_mie_en, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_tpc;

    function automatic vec_t mk(input logic iv, input logic [31:0] p, input logic exc,
                                input logic [31:0] c, input logic [31:0] v, input logic mr,
                                input logic [2:0] irq, input logic we, input logic [11:0] a,
                                input logic [31:0] wd, input logic er, input logic [31:0] ep,
                                input logic eb, input logic een);
        vec_t r;
        r.iv = iv; r.pc = p; r.exc = exc; r.cause = c; r.val = v; r.mret = mr;
        r.irq = irq; r.we = we; r.addr = a; r.wdata = wd;
        r.e_req = er; r.e_pc = ep; r.e_busy = eb; r.e_en = een;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_valid = v.iv; pc = v.pc; exception_taken = v.exc;
        exception_cause = v.cause; exception_val = v.val; mret = v.mret;
        irq_external = v.irq[2]; irq_software = v.irq[1]; irq_timer = v.irq[0];
        csr_we = v.we; csr_addr = v.addr; csr_wdata = v.wdata;
    endtask

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_redirect = 1'b0; m_treq = 1'b0; m_busy = 1'b0;
        m_mie_en = 32'h0; m_mtvec = RST_TVEC; m_mscratch = 32'h0; m_mepc = 32'h0;
        m_mcause = 32'h0; m_mtval = 32'h0; m_tpc = 32'h0;
    endtask

    function automatic logic [31:0] live_mip();
        return (irq_external ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) |
               (irq_software ? 32'h8 : 32'h0);
    endfunction

    // One clock edge of the architectural rules applied to the current inputs.
    task automatic model_step();
        int          code;
        logic [31:0] pend;
        int          prio[3];
        bit          is_irq, is_exc, is_mret;
        prio[0] = 11; prio[1] = 3; prio[2] = 7;
        is_irq = 1'b0; is_exc = 1'b0; is_mret = 1'b0; code = 0;
        if (m_redirect) begin
            m_redirect = 1'b0; m_treq = 1'b0; m_busy = 1'b0;
            return;
        end
        m_treq = 1'b0; m_busy = 1'b0;
        pend = m_mie_en & live_mip();
        if (instr_valid) begin
            if (m_mie) begin
                for (int k = 0; k < 3; k++) begin
                    if (!is_irq && pend[prio[k]]) begin
                        is_irq = 1'b1; code = prio[k];
                    end
                end
            end
            if (!is_irq && exception_taken) is_exc = 1'b1;
            else if (!is_irq && mret) is_mret = 1'b1;
        end
        if (is_irq || is_exc) begin
            m_mepc = pc & ~32'h3;
            m_mpie = m_mie; m_mie = 1'b0;
            m_tpc = m_mtvec & ~32'h3;
            if (is_irq) begin
                m_mcause = 32'h8000_0000 + code; m_mtval = 32'h0;
                if (m_mtvec[0]) m_tpc = m_tpc + 4 * code;
            end else begin
                m_mcause = exception_cause; m_mtval = exception_val;
            end
        end else if (is_mret) begin
            m_mie = m_mpie; m_mpie = 1'b1; m_tpc = m_mepc;
        end else if (csr_we) begin
            case (csr_addr)
                12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                12'h304: m_mie_en = csr_wdata & 32'h888;
                12'h305: m_mtvec = csr_wdata & ~32'h2;
                12'h340: m_mscratch = csr_wdata;
                12'h341: m_mepc = csr_wdata & ~32'h3;
                12'h342: m_mcause = csr_wdata;
                12'h343: m_mtval = csr_wdata;
                default: ;
            endcase
        end
        if (is_irq || is_exc || is_mret) begin
            m_redirect = 1'b1; m_treq = 1'b1; m_busy = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h304: return m_mie_en;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return live_mip();
            default: return 32'h0;
        endcase
    endfunction

    task automatic read_all();
        csr_we = 1'b0;
        for (int k = 0; k < 9; k++) begin
            csr_addr = addr_list[k];
            #1;
            chk($sformatf("csr_%h", addr_list[k]), csr_rdata, exp_rd(addr_list[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    initial begin
        vec_t r;
        addr_list[0] = 12'h300; addr_list[1] = 12'h304; addr_list[2] = 12'h305;
        addr_list[3] = 12'h340; addr_list[4] = 12'h341; addr_list[5] = 12'h342;
        addr_list[6] = 12'h343; addr_list[7] = 12'h344; addr_list[8] = 12'h7C0;

        //            iv  pc            exc c      val           mr irq     we  addr     wdata          req pc             bsy en
        vecs[0]  = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 1, 12'h305, 32'h100,       0, 32'h0,      0, 0);
        vecs[1]  = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 1, 12'h300, 32'h8,         0, 32'h0,      0, 1);
        vecs[2]  = mk(1, 32'h2000,     1, 2,     32'hFFFFFFFF, 0, 3'b000, 0, 12'h0,   32'h0,         1, 32'h100,    1, 0);
        vecs[3]  = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 1, 12'h340, 32'h1234,      0, 32'h100,    0, 0);
        vecs[4]  = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 1, 12'h305, 32'h201,       0, 32'h100,    0, 0);
        vecs[5]  = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 1, 12'h304, 32'hFFFFFFFF,  0, 32'h100,    0, 0);
        vecs[6]  = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 1, 12'h300, 32'h8,         0, 32'h100,    0, 1);
        vecs[7]  = mk(1, 32'h4000,     1, 11,    32'h55,       0, 3'b001, 0, 12'h0,   32'h0,         1, 32'h21C,    1, 0);
        vecs[8]  = mk(1, 32'h4000,     0, 0,     0,            0, 3'b001, 0, 12'h0,   32'h0,         0, 32'h21C,    0, 0);
        vecs[9]  = mk(1, 32'h4004,     0, 0,     0,            0, 3'b001, 0, 12'h0,   32'h0,         0, 32'h21C,    0, 0);
        vecs[10] = mk(0, 32'h0,        0, 0,     0,            0, 3'b111, 1, 12'h300, 32'h8,         0, 32'h21C,    0, 1);
        vecs[11] = mk(1, 32'h5000,     0, 0,     0,            0, 3'b111, 0, 12'h0,   32'h0,         1, 32'h22C,    1, 0);
        vecs[12] = mk(0, 32'h0,        0, 0,     0,            0, 3'b011, 0, 12'h0,   32'h0,         0, 32'h22C,    0, 0);
        vecs[13] = mk(0, 32'h0,        0, 0,     0,            0, 3'b011, 1, 12'h300, 32'h8,         0, 32'h22C,    0, 1);
        vecs[14] = mk(1, 32'h5004,     0, 0,     0,            0, 3'b011, 0, 12'h0,   32'h0,         1, 32'h20C,    1, 0);
        vecs[15] = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 0, 12'h0,   32'h0,         0, 32'h20C,    0, 0);
        vecs[16] = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 1, 12'h341, 32'h3004,      0, 32'h20C,    0, 0);
        vecs[17] = mk(1, 32'h7000,     0, 0,     0,            1, 3'b000, 0, 12'h0,   32'h0,         1, 32'h3004,   1, 1);
        vecs[18] = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 0, 12'h0,   32'h0,         0, 32'h3004,   0, 1);
        vecs[19] = mk(1, 32'h6000,     1, 5,     32'h7,        0, 3'b000, 1, 12'h340, 32'hDEAD,      1, 32'h200,    1, 0);
        vecs[20] = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 0, 12'h0,   32'h0,         0, 32'h200,    0, 0);
        vecs[21] = mk(0, 32'h0,        0, 0,     0,            0, 3'b000, 1, 12'h341, 32'h1003,      0, 32'h200,    0, 0);
        vecs[22] = mk(0, 32'h0,        0, 0,     0,            0, 3'b010, 1, 12'h344, 32'hFFF,       0, 32'h200,    0, 0);
        vecs[23] = mk(0, 32'h8000,     1, 4,     32'h9,        0, 3'b010, 0, 12'h0,   32'h0,         0, 32'h200,    0, 0);

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 12'h0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (2) @(posedge clk);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_trap_req", {31'h0, trap_req}, 32'h0);
        chk("rst_trap_pc", trap_pc, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_irq_en", {31'h0, irq_en}, 32'h0);
        read_all();

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("vec%0d_trap_req", i), {31'h0, trap_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("vec%0d_trap_pc", i), trap_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].e_busy});
            chk($sformatf("vec%0d_irq_en", i), {31'h0, irq_en}, {31'h0, vecs[i].e_en});
            read_all();
        end

        // asynchronous reset while the redirect strobe is high
        drive(mk(1, 32'h9000, 1, 3, 32'h44, 0, 3'b000, 0, 12'h0, 0, 0, 0, 0, 0));
        tick();
        chk("pre_rst_trap_req", {31'h0, trap_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_trap_req", {31'h0, trap_req}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_trap_pc", trap_pc, 32'h0);
        read_all();
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            r = mk(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0),
                   $urandom_range(0, 15), $urandom, ($urandom_range(0, 4) == 0),
                   3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                   addr_list[$urandom_range(0, 8)], $urandom, 0, 0, 0, 0);
            drive(r);
            tick();
            chk("rnd_trap_req", {31'h0, trap_req}, {31'h0, m_treq});
            chk("rnd_trap_pc", trap_pc, m_tpc);
            chk("rnd_busy", {31'h0, busy}, {31'h0, m_busy});
            chk("rnd_irq_en", {31'h0, irq_en}, {31'h0, m_mie});
            read_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
